// File: rtl/mem_issue_sched_pkg.sv
// mem_issue_sched_pkg: shared widths and the memory micro-op bundle
package mem_issue_sched_pkg;
    localparam int PR_ADDR_W = 6;
    localparam int MEM_OP_STORE_BIT = 0;
    localparam int ROB_TAG_W = 5;
    typedef struct packed {
        logic [3:0]           opcode;
        logic [ROB_TAG_W-1:0] rob_entry;
        logic [15:0]          base_val;
        logic [7:0]           offset;
        logic [PR_ADDR_W-1:0] dest_reg;
        logic [7:0]           data;
        logic [3:0]           imm;
        logic [3:0]           dest_arch_regs;
    } mem_uop_t;
endpackage

// File: rtl/mem_sched_fifo.sv
// mem_sched_fifo: circular buffer of mem_uop_t with flush; caller guarantees push only when not full, pop only when not empty
module mem_sched_fifo
    import mem_issue_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  mem_uop_t         wdata,
    output mem_uop_t         rdata,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    mem_uop_t mem [DEPTH];
    logic [PTR_W-1:0] wp, rp;
    assign rdata = mem[rp];
    always_ff @(posedge clk)
        if (push) mem[wp] <= wdata;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: rtl/mem_issue_sched.sv
// mem_issue_sched: in-order memory op issue, stores held until ROB head; MEM_SCHED_BYPASS_EN adds empty-queue bypass
module mem_issue_sched
    import mem_issue_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           in_opcode,
    input  logic [ROB_TAG_W-1:0] in_ROB_entry,
    input  logic [15:0]          in_base_val,
    input  logic [7:0]           in_offset,
    input  logic [PR_ADDR_W-1:0] in_dest_reg,
    input  logic [7:0]           in_data,
    input  logic [3:0]           in_imm,
    input  logic [3:0]           in_dest_arch_regs,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROB_TAG_W-1:0] rob_head,
    input  logic                 flush,
    output logic [3:0]           out_opcode,
    output logic [ROB_TAG_W-1:0] out_ROB_entry,
    output logic [15:0]          out_base_val,
    output logic [7:0]           out_offset,
    output logic [PR_ADDR_W-1:0] out_dest_reg,
    output logic [7:0]           out_data,
    output logic [3:0]           out_imm,
    output logic [3:0]           out_dest_arch_regs,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     count,
    output logic                 store_blocked
);
    mem_uop_t in_uop, head, sel;
    logic nonempty, head_ok, byp, push, pop;
    assign in_uop = '{in_opcode, in_ROB_entry, in_base_val, in_offset, in_dest_reg, in_data, in_imm, in_dest_arch_regs};
    assign nonempty = count != '0;
    assign in_ready = count != CNT_W'(DEPTH);
    assign head_ok = nonempty && (!head.opcode[MEM_OP_STORE_BIT] || head.rob_entry == rob_head);
    assign store_blocked = nonempty && head.opcode[MEM_OP_STORE_BIT] && head.rob_entry != rob_head;
`ifdef MEM_SCHED_BYPASS_EN
    assign byp = !nonempty && in_valid && out_ready && !flush &&
                 (!in_opcode[MEM_OP_STORE_BIT] || in_ROB_entry == rob_head);
`else
    assign byp = 1'b0;
`endif
    assign sel = byp ? in_uop : head;
    assign out_valid = (head_ok || byp) && !flush;
    assign push = in_valid && in_ready && !flush && !byp;
    assign pop = head_ok && out_ready && !flush;
    assign {out_opcode, out_ROB_entry, out_base_val, out_offset, out_dest_reg, out_data, out_imm, out_dest_arch_regs} = sel;
    mem_sched_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop),
        .wdata(in_uop), .rdata(head), .count(count)
    );
endmodule

// File: tb/tb_mem_issue_sched.sv
// tb_mem_issue_sched: directed checks of ordering, store gating, full, flush, wrap and bypass
module tb_mem_issue_sched;
    import mem_issue_sched_pkg::*;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] in_opcode = '0;
    logic [ROB_TAG_W-1:0] in_ROB_entry = '0;
    logic [15:0] in_base_val = '0;
    logic [7:0] in_offset = '0;
    logic [PR_ADDR_W-1:0] in_dest_reg = '0;
    logic [7:0] in_data = '0;
    logic [3:0] in_imm = '0;
    logic [3:0] in_dest_arch_regs = '0;
    logic in_valid = 1'b0, in_ready;
    logic [ROB_TAG_W-1:0] rob_head = '0;
    logic flush = 1'b0;
    logic [3:0] out_opcode;
    logic [ROB_TAG_W-1:0] out_ROB_entry;
    logic [15:0] out_base_val;
    logic [7:0] out_offset;
    logic [PR_ADDR_W-1:0] out_dest_reg;
    logic [7:0] out_data;
    logic [3:0] out_imm;
    logic [3:0] out_dest_arch_regs;
    logic out_valid, out_ready = 1'b0;
    logic [CNT_W-1:0] count;
    logic store_blocked;
    int checks = 0, failures = 0;
    mem_issue_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_opcode(in_opcode), .in_ROB_entry(in_ROB_entry),
        .in_base_val(in_base_val), .in_offset(in_offset), .in_dest_reg(in_dest_reg),
        .in_data(in_data), .in_imm(in_imm), .in_dest_arch_regs(in_dest_arch_regs),
        .in_valid(in_valid), .in_ready(in_ready), .rob_head(rob_head), .flush(flush),
        .out_opcode(out_opcode), .out_ROB_entry(out_ROB_entry), .out_base_val(out_base_val),
        .out_offset(out_offset), .out_dest_reg(out_dest_reg), .out_data(out_data),
        .out_imm(out_imm), .out_dest_arch_regs(out_dest_arch_regs), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .store_blocked(store_blocked)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic set_op(input logic st, input int tag);
        in_opcode = {3'b010, st};
        in_ROB_entry = ROB_TAG_W'(tag);
        in_base_val = 16'(tag * 16'h0101);
        in_offset = 8'(tag + 3);
        in_dest_reg = PR_ADDR_W'(tag);
        in_data = 8'(tag ^ 8'h5a);
        in_imm = 4'(tag);
        in_dest_arch_regs = 4'(tag + 1);
    endtask
    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_store_blocked", store_blocked, 0);
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_op(1'b0, i);
            in_valid = 1'b1;
            tick();
            chk("load_valid", out_valid, 1);
            chk("load_tag", out_ROB_entry, i);
            chk("load_base", out_base_val, i * 16'h0101);
            chk("load_count", count, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("load_drain_count", count, 0);
        chk("load_drain_valid", out_valid, 0);
        rob_head = 5'd2;
        set_op(1'b1, 4);
        in_valid = 1'b1;
        tick();
        set_op(1'b0, 5);
        tick();
        in_valid = 1'b0;
        chk("st_blocked", store_blocked, 1);
        chk("st_out_valid", out_valid, 0);
        chk("st_count", count, 2);
        tick();
        chk("st_still_blocked", count, 2);
        rob_head = 5'd4;
        #1;
        chk("st_release_valid", out_valid, 1);
        chk("st_release_tag", out_ROB_entry, 4);
        chk("st_release_data", out_data, 8'(4 ^ 8'h5a));
        chk("st_release_sb", store_blocked, 0);
        tick();
        chk("ld_after_st_tag", out_ROB_entry, 5);
        chk("ld_after_st_valid", out_valid, 1);
        tick();
        chk("st_drain_count", count, 0);
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_op(1'b0, 8 + i);
            in_valid = 1'b1;
            tick();
        end
        chk("full_count", count, DEPTH);
        chk("full_in_ready", in_ready, 0);
        set_op(1'b0, 20);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("full_no_pushthrough", count, DEPTH - 1);
        chk("full_ready_back", in_ready, 1);
        for (int i = 1; i < DEPTH; i++) begin
            chk("full_order", out_ROB_entry, 8 + i);
            tick();
        end
        chk("full_drained", count, 0);
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_op(1'b0, i);
            in_valid = 1'b1;
            tick();
        end
        set_op(1'b0, 30);
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("flush_cycle_valid", out_valid, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        set_op(1'b0, 6);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_flush_tag", out_ROB_entry, 6);
        chk("post_flush_count", count, 1);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(1'b0, i);
            in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_op(1'b0, i + 3);
            chk("wrap_tag", out_ROB_entry, i);
            chk("wrap_base", out_base_val, i * 16'h0101);
            tick();
            chk("wrap_count", count, 3);
        end
        in_valid = 1'b0;
        for (int i = 20; i < 23; i++) begin
            chk("wrap_drain_tag", out_ROB_entry, i);
            tick();
        end
        chk("wrap_drain_count", count, 0);
        out_ready = 1'b0;
        set_op(1'b0, 9);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_valid", out_valid, 0);
        out_ready = 1'b1;
        set_op(1'b0, 7);
        in_base_val = 16'h1234;
        in_valid = 1'b1;
        #1;
`ifdef MEM_SCHED_BYPASS_EN
        chk("byp_valid", out_valid, 1);
        chk("byp_base", out_base_val, 16'h1234);
        tick();
        in_valid = 1'b0;
        chk("byp_count", count, 0);
`else
        chk("nobyp_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("nobyp_count", count, 1);
        chk("nobyp_base", out_base_val, 16'h1234);
        tick();
`endif
        chk("end_count", count, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
